// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: size encodings, FSM states
// and the request decode helpers used for alignment and byte-lane selection.
package dmem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } stateT;

    // Reserved size (2'b11) is reported as misaligned so it never reaches the RAM.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: isMisaligned = 1'b0;
            SZ_HALF: isMisaligned = lo[0];
            SZ_WORD: isMisaligned = (lo != 2'b00);
            default: isMisaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: laneMask = 4'b0001 << lo;
            SZ_HALF: laneMask = 4'b0011 << lo;
            default: laneMask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_bank.sv
// dmem_bank: single-port synchronous RAM of 32-bit words split into four byte
// lanes, each with its own write enable; reads are registered and return old data.
module dmem_bank #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gLane
            logic [7:0] laneMem [DEPTH];
            logic [7:0] laneRdReg;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) begin
                        if (be[gi]) begin
                            laneMem[addr] <= wdata[8*gi +: 8];
                        end
                    end else begin
                        laneRdReg <= laneMem[addr];
                    end
                end
            end

            assign rdata[8*gi +: 8] = laneRdReg;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: accepts aligned load/store requests, stalls the
// pipeline for WAIT_CYCLES+1 cycles, then completes. Optional stats via DMEM_STATS_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall_req,
    output logic        addr_err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    // The accepting IDLE cycle is the first stalled cycle, so BUSY lasts
    // WAIT_CYCLES cycles and the counter holds the BUSY cycles still to come.
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    stateT       stateReg, stateNext;
    logic [3:0]  cntReg, cntNext;
    logic [31:0] rdataHoldReg;
    logic        misaligned;
    logic        readEn, writeEn;
    logic        loadDone;
    logic [3:0]  laneBe;
    logic [31:0] laneWdata;
    logic [31:0] bankRdata;
    logic [31:0] shiftedRdata;
    logic [31:0] loadData;
    logic        unusedAddrBits;

    assign unusedAddrBits = ^req_addr[31:ADDR_WIDTH+2];

    assign misaligned = isMisaligned(req_size, req_addr[1:0]);
    assign addr_err   = !rst && req_en && misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= S_IDLE;
            cntReg   <= 4'd0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            S_IDLE: begin
                if (req_en && !misaligned) begin
                    if (NO_WAIT) begin
                        stateNext = S_DONE;
                    end else begin
                        stateNext = S_BUSY;
                        cntNext   = CNT_INIT;
                    end
                end
            end
            S_BUSY: begin
                if (!req_en) begin
                    stateNext = S_IDLE;
                end else if (cntReg == 4'd0) begin
                    stateNext = S_DONE;
                end else begin
                    cntNext = 4'(cntReg - 4'd1);
                end
            end
            S_DONE:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // The RAM word is fetched on the edge into DONE; stores commit on the edge out of it.
    always_comb begin
        stall_req = 1'b0;
        readEn    = 1'b0;
        writeEn   = 1'b0;
        if (!rst) begin
            case (stateReg)
                S_IDLE: begin
                    stall_req = req_en && !misaligned;
                    readEn    = NO_WAIT && req_en && !misaligned;
                end
                S_BUSY: begin
                    stall_req = 1'b1;
                    readEn    = req_en && (cntReg == 4'd0);
                end
                S_DONE:  writeEn = req_we;
                default: ;
            endcase
        end
    end

    always_comb begin
        laneBe = laneMask(req_size, req_addr[1:0]);
        case (req_size)
            SZ_BYTE: laneWdata = {4{req_wdata[7:0]}};
            SZ_HALF: laneWdata = {2{req_wdata[15:0]}};
            default: laneWdata = req_wdata;
        endcase
    end

    dmem_bank #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) uBank (
        .clk  (clk),
        .en   (readEn || writeEn),
        .we   (writeEn),
        .be   (laneBe),
        .addr (req_addr[ADDR_WIDTH+1:2]),
        .wdata(laneWdata),
        .rdata(bankRdata)
    );

    always_comb begin
        shiftedRdata = bankRdata >> {req_addr[1:0], 3'b000};
        case (req_size)
            SZ_BYTE: loadData = {{24{~req_unsigned & shiftedRdata[7]}}, shiftedRdata[7:0]};
            SZ_HALF: loadData = {{16{~req_unsigned & shiftedRdata[15]}}, shiftedRdata[15:0]};
            default: loadData = shiftedRdata;
        endcase
    end

    assign loadDone = !rst && (stateReg == S_DONE) && !req_we;
    assign rdata    = loadDone ? loadData : rdataHoldReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdataHoldReg <= 32'd0;
        end else if (loadDone) begin
            rdataHoldReg <= loadData;
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] rdCountReg, wrCountReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdCountReg <= 32'd0;
            wrCountReg <= 32'd0;
        end else if (stateReg == S_DONE) begin
            if (req_we) begin
                wrCountReg <= wrCountReg + 32'd1;
            end else begin
                rdCountReg <= rdCountReg + 32'd1;
            end
        end
    end

    assign rd_count = rdCountReg;
    assign wr_count = wrCountReg;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic checked against
// a byte-addressed memory model; build with DMEM_STATS_EN to also check counters.
module tb_dmem_responder;

    localparam int WAIT = 1;

    logic        clk;
    logic        rst;
    logic        req_en;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        stall_req;
    logic        addr_err;
`ifdef DMEM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    int passCnt  = 0;
    int failCnt  = 0;
    int totalCnt = 0;
    int expRd    = 0;
    int expWr    = 0;

    logic [7:0] mdl [4096];

    dmem_responder #(
        .ADDR_WIDTH (10),
        .WAIT_CYCLES(WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_en      (req_en),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rdata       (rdata),
        .stall_req   (stall_req),
        .addr_err    (addr_err)
`ifdef DMEM_STATS_EN
        ,
        .rd_count    (rd_count),
        .wr_count    (wr_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) begin
            passCnt++;
            $display("chk %-24s obs=0x%08h exp=0x%08h ok", tag, obs, exp);
        end else begin
            failCnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int stalls, output logic err);
        @(negedge clk);
        req_en       = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        #1;
        err    = addr_err;
        stalls = 0;
        while (stall_req === 1'b1 && stalls < 40) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        rd = rdata;
    endtask

    // Expected results come from the byte model: little-endian gather, then extend.
    task automatic runOp(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd);
        logic        bad;
        int          nb;
        int          base;
        logic [31:0] exp;
        int          stalls;
        logic        err;
        bad  = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        base = int'(addr[11:0]);
        exp  = 32'd0;
        for (int i = 0; i < nb; i++) begin
            exp = exp | (32'(mdl[(base + i) % 4096]) << (8 * i));
        end
        if (!uns && nb < 4 && exp[8*nb-1]) begin
            exp = exp | ~((32'd1 << (8 * nb)) - 32'd1);
        end
        access(we, size, uns, addr, wd, rd, stalls, err);
        $display("op %-10s we=%0b sz=%0d u=%0b addr=0x%08h wd=0x%08h rd=0x%08h stalls=%0d err=%0b",
                 tag, we, size, uns, addr, wd, rd, stalls, err);
        check({tag, " addr_err"}, 32'(err), 32'(bad));
        check({tag, " stalls"}, 32'(stalls), bad ? 32'd0 : 32'(WAIT + 1));
        if (!bad && !we) begin
            check({tag, " rdata"}, rd, exp);
            expRd++;
        end
        if (!bad && we) begin
            for (int i = 0; i < nb; i++) begin
                mdl[(base + i) % 4096] = wd[8*i +: 8];
            end
            expWr++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsz;
        logic        rwe;

        rst = 1'b1; req_en = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset stall_req", 32'(stall_req), 32'd0);
        check("reset addr_err", 32'(addr_err), 32'd0);
        check("reset rdata", rdata, 32'd0);
`ifdef DMEM_STATS_EN
        check("reset rd_count", rd_count, 32'd0);
        check("reset wr_count", wr_count, 32'd0);
`endif

        runOp("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd);
        runOp("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);
        check("lw10 literal", rd, 32'hDEADBEEF);

        runOp("sb13", 1'b1, 2'd0, 1'b0, 32'h13, 32'h80, rd);
        runOp("lb13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd);
        check("lb13 literal", rd, 32'hFFFFFF80);
        runOp("lbu13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd);
        check("lbu13 literal", rd, 32'h00000080);
        runOp("sh12", 1'b1, 2'd1, 1'b0, 32'h12, 32'h8001, rd);
        runOp("lhu12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd);
        check("lhu12 literal", rd, 32'h00008001);
        runOp("lh12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd);
        check("lh12 literal", rd, 32'hFFFF8001);

        runOp("sw20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, rd);
        runOp("sb21", 1'b1, 2'd0, 1'b0, 32'h21, 32'hAA, rd);
        runOp("lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd);
        check("lw20 literal", rd, 32'h1122AA44);

        runOp("lw22bad", 1'b0, 2'd2, 1'b0, 32'h22, 32'h0, rd);
        runOp("sw22bad", 1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFFFFFF, rd);
        runOp("lw20b", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd);
        check("lw20b literal", rd, 32'h1122AA44);

`ifdef DMEM_STATS_EN
        @(negedge clk); #1;
        check("stats rd_count", rd_count, 32'(expRd));
        check("stats wr_count", wr_count, 32'(expWr));
`endif

        // Store abandoned by a reset pulse while BUSY.
        runOp("sw30", 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D, rd);
        @(negedge clk);
        req_en = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h30; req_wdata = 32'h55;
        #1;
        check("rstmid t0 stall", 32'(stall_req), 32'd1);
        @(negedge clk); #1;
        check("rstmid busy stall", 32'(stall_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req_en = 1'b0;
        #1;
        check("rstmid idle stall", 32'(stall_req), 32'd0);
        check("rstmid rdata", rdata, 32'd0);
        expRd = 0;
        expWr = 0;
        runOp("lw30", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd);
        check("lw30 literal", rd, 32'hCAFEF00D);

        // Store abandoned by req_en dropping while BUSY.
        runOp("sw34", 1'b1, 2'd2, 1'b0, 32'h34, 32'h01020304, rd);
        @(negedge clk);
        req_en = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h34; req_wdata = 32'h77;
        @(negedge clk); #1;
        check("drop busy stall", 32'(stall_req), 32'd1);
        req_en = 1'b0;
        @(negedge clk); #1;
        check("drop idle stall", 32'(stall_req), 32'd0);
        runOp("lw34", 1'b0, 2'd2, 1'b0, 32'h34, 32'h0, rd);
        check("lw34 literal", rd, 32'h01020304);

        for (int a = 32'h100; a < 32'h200; a += 4) begin
            runOp("init", 1'b1, 2'd2, 1'b0, 32'(a), $urandom, rd);
        end
        for (int n = 0; n < 80; n++) begin
            rwe = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            runOp("rand", rwe, rsz, 1'($urandom_range(0, 1)),
                  32'h100 + 32'($urandom_range(0, 255)), $urandom, rd);
        end

`ifdef DMEM_STATS_EN
        @(negedge clk); #1;
        check("final rd_count", rd_count, 32'(expRd));
        check("final wr_count", wr_count, 32'(expWr));
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
